// File: rtl/upsp_frame_sequencer.sv
// rtl/upsp_frame_sequencer.sv - AXI4-Lite master stepping the upsampler through a batch of frames
// Optional watchdog: define UPSP_SEQ_TIMEOUT_EN.
module upsp_frame_sequencer #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_UPSTART    = AXI_ADDR_WIDTH'(32'h0),
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_UPEND      = AXI_ADDR_WIDTH'(32'h4),
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_UPINHSKCNT = AXI_ADDR_WIDTH'(32'h8),
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [FRAME_CNT_WIDTH-1:0]    frame_num,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [FRAME_CNT_WIDTH-1:0]    frame_cnt,
    output logic [AXI_DATA_WIDTH-1:0]     last_hskcnt,
    input  logic                          interrupt_updone,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp
);

    typedef enum logic [2:0] {
        IDLE, WR_START, WR_START_B, WAIT_DONE, RD_CNT, RD_CNT_R, WR_END, WR_END_B
    } state_t;

    state_t state_q, state_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_num_q, frame_cnt_q, frame_cnt_inc;
    logic [AXI_DATA_WIDTH-1:0]  hskcnt_q;
    logic err_q, done_q;
    logic in_wr, aw_ok, w_ok;
    logic latch_start, frame_inc, set_err, set_done, tmo_hit;

    assign frame_cnt_inc = frame_cnt_q + {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    assign in_wr = (state_q == WR_START) || (state_q == WR_END);
    // A channel counts as accepted if it finished earlier or is handshaking now.
    assign aw_ok = aw_done_q || m_axi_awready;
    assign w_ok  = w_done_q  || m_axi_wready;

    assign m_axi_awvalid = in_wr && !aw_done_q;
    assign m_axi_wvalid  = in_wr && !w_done_q;
    assign m_axi_awaddr  = (state_q == WR_END) ? ADDR_UPEND :
                           (state_q == WR_START) ? ADDR_UPSTART : '0;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = {{(AXI_DATA_WIDTH-1){1'b0}}, 1'b1};
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = (state_q == WR_START_B) || (state_q == WR_END_B);
    assign m_axi_arvalid = (state_q == RD_CNT);
    assign m_axi_araddr  = (state_q == RD_CNT) ? ADDR_UPINHSKCNT : '0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == RD_CNT_R);

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign frame_cnt   = frame_cnt_q;
    assign last_hskcnt = hskcnt_q;

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        latch_start = 1'b0;
        frame_inc   = 1'b0;
        set_err     = 1'b0;
        set_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_start = 1'b1;
                    if (frame_num == '0) set_done = 1'b1;
                    else                 state_d  = WR_START;
                end
            end
            WR_START, WR_END: begin
                if (aw_ok && w_ok) begin
                    state_d   = (state_q == WR_START) ? WR_START_B : WR_END_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            WR_START_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        set_err  = 1'b1;
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: if (interrupt_updone) state_d = RD_CNT;
            RD_CNT:    if (m_axi_arready) state_d = RD_CNT_R;
            RD_CNT_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        set_err  = 1'b1;
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WR_END;
                    end
                end
            end
            WR_END_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        set_err  = 1'b1;
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_inc = 1'b1;
                        if (frame_cnt_inc == frame_num_q) begin
                            set_done = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = WR_START;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog overrides any in-flight step and abandons the transfer.
        if (tmo_hit) begin
            state_d   = IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            frame_inc = 1'b0;
            set_err   = 1'b1;
            set_done  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            frame_num_q <= '0;
            frame_cnt_q <= '0;
            hskcnt_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= set_done;
            if (latch_start) begin
                frame_num_q <= frame_num;
                frame_cnt_q <= '0;
                err_q       <= 1'b0;
            end else begin
                if (frame_inc) frame_cnt_q <= frame_cnt_inc;
                if (set_err)   err_q       <= 1'b1;
            end
            if ((state_q == RD_CNT_R) && m_axi_rvalid) hskcnt_q <= m_axi_rdata;
        end
    end

`ifdef UPSP_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     tmo_q <= '0;
        else if ((state_d != state_q) || (state_q == IDLE)) tmo_q <= '0;
        else                                            tmo_q <= tmo_q + TMO_W'(1);
    end
`else
    logic unused_tmo_cfg;
    assign tmo_hit        = 1'b0;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_upsp_frame_sequencer.sv
// tb/tb_upsp_frame_sequencer.sv - scoreboard bench for upsp_frame_sequencer
`timescale 1ns/1ps
module tb_upsp_frame_sequencer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic [FW-1:0] frame_num = '0;
    logic busy, done, err;
    logic [FW-1:0] frame_cnt;
    logic [DW-1:0] last_hskcnt;
    logic intr;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0] m_axi_awprot, m_axi_arprot;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [1:0] m_axi_bresp, m_axi_rresp;

    upsp_frame_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_num(frame_num),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt), .last_hskcnt(last_hskcnt),
        .interrupt_updone(intr),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp)
    );

    // Slave model: programmable ready delays, error injection on write index, delayed interrupt.
    int aw_dly = 0, w_dly = 0, err_wr = 0;
    int aw_cnt, w_cnt, wr_idx, irq_cnt;
    bit intr_en = 1'b1;
    logic [DW-1:0] rdata_val = 32'h1234;
    logic aw_got, w_got;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
    assign m_axi_arready = 1'b1;
    assign m_axi_rresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; wr_idx <= 0; irq_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; intr <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rdata <= '0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
            if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
                (w_got || (m_axi_wvalid && m_axi_wready)) && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (wr_idx + 1 == err_wr) ? 2'b10 : 2'b00;
                wr_idx <= wr_idx + 1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || (m_axi_awvalid && m_axi_awready);
                w_got  <= w_got || (m_axi_wvalid && m_axi_wready);
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready && !m_axi_rvalid) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= rdata_val;
            end else if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                intr <= 1'b0;
                irq_cnt <= (m_axi_awaddr == 32'h0) ? 20 : 0;
            end else if (irq_cnt != 0) begin
                irq_cnt <= irq_cnt - 1;
                if (irq_cnt == 1 && intr_en) intr <= 1'b1;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_done = 0, done_cyc = 0, act_cnt = 0;
    int n_aw = 0, n_w = 0, n_b = 0, last_b_cyc = 0;
    bit aw_acc, w_acc, p_aw, p_w;
    logic [AW-1:0] p_addr;
    logic [AW-1:0] exp_addr[$];

    // Every wait goes through here: advance to the next falling edge and run protocol/scoreboard checks.
    task automatic tick();
        logic [AW-1:0] e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            aw_acc = 0; w_acc = 0; p_aw = 0; p_w = 0;
            return;
        end
        n_cmp++;
        if (m_axi_bready && !(aw_acc && w_acc)) begin
            n_bad++; $display("FAIL bready_early: aw_acc=%0b w_acc=%0b required both 1", aw_acc, w_acc);
        end
        if (m_axi_arvalid && (aw_acc || w_acc || m_axi_awvalid || m_axi_wvalid)) begin
            n_bad++; $display("FAIL ar_overlap: arvalid=1 during write, required no overlap");
        end
        if ((m_axi_awvalid && aw_acc) || (m_axi_wvalid && w_acc)) begin
            n_bad++; $display("FAIL dup_beat: awvalid=%0b wvalid=%0b after acceptance, required 0", m_axi_awvalid, m_axi_wvalid);
        end
        if ((p_aw && (!m_axi_awvalid || m_axi_awaddr !== p_addr)) || (p_w && !m_axi_wvalid)) begin
            n_bad++; $display("FAIL unstable: awvalid=%0b awaddr=%h wvalid=%0b, required held", m_axi_awvalid, m_axi_awaddr, m_axi_wvalid);
        end
        if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) act_cnt++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (m_axi_awvalid && m_axi_awready) begin
            n_aw++; n_cmp++;
            if (exp_addr.size() == 0) begin
                n_bad++; $display("FAIL aw_unexpected: awaddr=%h, required no write", m_axi_awaddr);
            end else begin
                e = exp_addr.pop_front();
                if (m_axi_awaddr !== e) begin
                    n_bad++; $display("FAIL aw_addr: got %h required %h", m_axi_awaddr, e);
                end
            end
        end
        if (m_axi_wvalid && m_axi_wready) begin
            n_w++; n_cmp++;
            if (m_axi_wdata !== 32'h1 || m_axi_wstrb !== 4'hf) begin
                n_bad++; $display("FAIL wdata: got %h/%h required 00000001/f", m_axi_wdata, m_axi_wstrb);
            end
        end
        p_aw = m_axi_awvalid && !m_axi_awready;
        p_w  = m_axi_wvalid && !m_axi_wready;
        p_addr = m_axi_awaddr;
        if (m_axi_bvalid && m_axi_bready) begin
            aw_acc = 0; w_acc = 0; n_b++; last_b_cyc = cyc;
        end else begin
            aw_acc = aw_acc || (m_axi_awvalid && m_axi_awready);
            w_acc  = w_acc || (m_axi_wvalid && m_axi_wready);
        end
    endtask

    task automatic start_batch(input int n);
        tick();
        start = 1'b1;
        frame_num = FW'(n);
        tick();
        start = 1'b0;
        frame_num = FW'($urandom);
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            seen = done;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL %s_done_timeout: no done within %0d cycles", name, max_cyc);
        end else if (busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_busy_at_done: busy=%0b required 0", name, busy);
        end
    endtask

    task automatic push_frames(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'h0);
            exp_addr.push_back(32'h4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, err, frame_cnt, last_hskcnt, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_arvalid, m_axi_rready, m_axi_awprot, m_axi_arprot} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b cnt=%0d hsk=%h required all 0",
                              busy, done, err, frame_cnt, last_hskcnt);
        end
        n_cmp++;
        if (m_axi_wstrb !== 4'hf || m_axi_wdata !== 32'h1) begin
            n_bad++; $display("FAIL reset_consts: wstrb=%h wdata=%h required f/00000001", m_axi_wstrb, m_axi_wdata);
        end
    endtask

    task automatic test_basic();
        n_done = 0; n_aw = 0;
        push_frames(3);
        start_batch(3);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy=%0b required 1", busy); end
        repeat (30) tick();
        start = 1'b1; frame_num = 16'd7;
        tick();
        start = 1'b0;
        wait_done(2000, "basic");
        n_cmp++;
        if (frame_cnt !== 16'd3 || last_hskcnt !== 32'h1234 || err !== 1'b0) begin
            n_bad++; $display("FAIL basic_result: cnt=%0d hsk=%h err=%0b required 3/00001234/0", frame_cnt, last_hskcnt, err);
        end
        repeat (10) tick();
        n_cmp++;
        if (n_done !== 1 || n_aw !== 6 || exp_addr.size() !== 0) begin
            n_bad++; $display("FAIL basic_traffic: done_pulses=%0d aw=%0d left=%0d required 1/6/0", n_done, n_aw, exp_addr.size());
        end
    endtask

    task automatic test_skew();
        for (int k = 0; k < 2; k++) begin
            aw_dly = (k == 0) ? 5 : 0;
            w_dly  = (k == 0) ? 0 : 5;
            n_aw = 0; n_w = 0;
            push_frames(1);
            start_batch(1);
            wait_done(500, "skew");
            repeat (3) tick();
            n_cmp++;
            if (n_aw !== 2 || n_w !== 2 || frame_cnt !== 16'd1 || err !== 1'b0 || exp_addr.size() !== 0) begin
                n_bad++; $display("FAIL skew%0d: aw=%0d w=%0d cnt=%0d err=%0b required 2/2/1/0", k, n_aw, n_w, frame_cnt, err);
            end
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_bresp_err();
        int snap;
        n_done = 0;
        err_wr = wr_idx + 3;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h0);
        start_batch(3);
        wait_done(1000, "bresp");
        n_cmp++;
        if (err !== 1'b1 || frame_cnt !== 16'd1) begin
            n_bad++; $display("FAIL bresp_result: err=%0b cnt=%0d required 1/1", err, frame_cnt);
        end
        snap = act_cnt;
        repeat (50) tick();
        n_cmp++;
        if (act_cnt !== snap || exp_addr.size() !== 0 || n_done !== 1) begin
            n_bad++; $display("FAIL bresp_quiet: extra_valid_cycles=%0d left=%0d done_pulses=%0d required 0/0/1",
                              act_cnt - snap, exp_addr.size(), n_done);
        end
        err_wr = 0;
    endtask

    task automatic test_zero_frames();
        int snap = act_cnt;
        start_batch(0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: done=%0b busy=%0b err=%0b required 1/0/0", done, busy, err);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL zero_after: done=%0b busy=%0b required 0/0", done, busy);
        end
        repeat (10) tick();
        n_cmp++;
        if (act_cnt !== snap) begin
            n_bad++; $display("FAIL zero_traffic: valid_cycles=%0d required 0", act_cnt - snap);
        end
    endtask

    task automatic test_reset_mid();
        int b0 = n_b;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h0);
        start_batch(3);
        for (int i = 0; i < 500 && (n_b - b0) < 3; i++) tick();
        n_cmp++;
        if (n_b - b0 != 3) begin n_bad++; $display("FAIL rstmid_reach: b_handshakes=%0d required 3", n_b - b0); end
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, frame_cnt, last_hskcnt, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_arvalid, m_axi_rready, m_axi_awaddr, m_axi_araddr} !== '0) begin
            n_bad++; $display("FAIL rstmid_async: busy=%0b cnt=%0d hsk=%h awv=%0b arv=%0b required all 0",
                              busy, frame_cnt, last_hskcnt, m_axi_awvalid, m_axi_arvalid);
        end
        exp_addr.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        rdata_val = 32'h00ab;
        push_frames(1);
        start_batch(1);
        wait_done(500, "rstmid");
        n_cmp++;
        if (frame_cnt !== 16'd1 || err !== 1'b0 || last_hskcnt !== 32'h00ab || exp_addr.size() !== 0) begin
            n_bad++; $display("FAIL rstmid_rerun: cnt=%0d err=%0b hsk=%h required 1/0/000000ab", frame_cnt, err, last_hskcnt);
        end
    endtask

`ifdef UPSP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        intr_en = 1'b0;
        exp_addr.push_back(32'h0);
        start_batch(1);
        wait_done(500, "timeout");
        n_cmp++;
        if (err !== 1'b1 || frame_cnt !== 16'd0 || done_cyc - (last_b_cyc + 1) != 64) begin
            n_bad++; $display("FAIL timeout: err=%0b cnt=%0d delay=%0d required 1/0/64", err, frame_cnt, done_cyc - (last_b_cyc + 1));
        end
        intr_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_bresp_err();
        test_zero_frames();
        test_reset_mid();
`ifdef UPSP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/upsp_frame_sequencer.md
Name: upsp_frame_sequencer

Overview:
- AXI4-Lite master that sequences the upsampling engine through a batch of frames by programming the config register file.
- Per frame it performs four steps: write UPSTART, wait for interrupt_updone, read the UPINHSKCNT handshake count, write UPEND to clear.
- Sits between the host/test controller and the s_axi port of the config register file, so multi-frame runs need no host intervention.

Parameters:
- AXI_DATA_WIDTH, 32, AXI-Lite data width.
- AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- ADDR_UPSTART, 32'h0, byte address of UPSTART register.
- ADDR_UPEND, 32'h4, byte address of UPEND register.
- ADDR_UPINHSKCNT, 32'h8, byte address of UPINHSKCNT register.
- FRAME_CNT_WIDTH, 16, width of frame counters.
- TIMEOUT_CYCLES, 1048576, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a batch; ignored unless idle.
- frame_num  in  FRAME_CNT_WIDTH  frames in batch; sampled on start; 0 means no AXI traffic.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse at batch end.
- err  out  1  sticky error; cleared on next accepted start.
- frame_cnt  out  FRAME_CNT_WIDTH  frames completed in current batch.
- last_hskcnt  out  AXI_DATA_WIDTH  last UPINHSKCNT value read.
- interrupt_updone  in  1  level from config register file; frame done.
- m_axi_awvalid/awready  out/in  1  write address handshake.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_wvalid/wready  out/in  1  write data handshake.
- m_axi_wdata  out  AXI_DATA_WIDTH  write data; always 1.
- m_axi_wstrb  out  AXI_DATA_WIDTH/8  all ones.
- m_axi_bvalid/bready  in/out  1  write response handshake.
- m_axi_bresp  in  2  write response.
- m_axi_arvalid/arready  out/in  1  read address handshake.
- m_axi_araddr  out  AXI_ADDR_WIDTH  read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_rvalid/rready  in/out  1  read data handshake.
- m_axi_rdata  in  AXI_DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.

Behaviour:
- Reset: all outputs 0 except constants (awprot/arprot 0, wstrb all ones, wdata 1). State IDLE, counters 0.
- Reset mid-transaction: abandons any outstanding AXI transfer immediately and returns to IDLE.
- States: IDLE -> WR_START -> WR_START_B -> WAIT_DONE -> RD_CNT -> RD_CNT_R -> WR_END -> WR_END_B -> (FRAME_CHK) -> IDLE or WR_START.
- IDLE + start:
  - Latch frame_num; clear frame_cnt and err.
  - If frame_num==0: done pulses the next cycle, busy stays 0.
  - Otherwise: busy=1 from the next cycle.
- WR_START / WR_END write phase:
  - Assert awvalid and wvalid together (awaddr=ADDR_UPSTART or ADDR_UPEND).
  - Each valid drops on its own handshake; AW and W may complete in either order or the same cycle.
  - Advance to the _B state once both are accepted.
  - Valids and their payloads stay stable until accepted.
- _B states: bready=1. On bvalid, bresp!=2'b00 sets err and jumps to IDLE (busy=0, done pulse); otherwise advance.
- WAIT_DONE: wait for interrupt_updone==1 (level; a 1 on the entry cycle is honoured); then go to RD_CNT.
- RD_CNT: arvalid=1, araddr=ADDR_UPINHSKCNT, held until arready.
- RD_CNT_R:
  - rready=1. On rvalid: last_hskcnt<=rdata.
  - rresp!=OKAY sets err and aborts as in the _B states.
- WR_END_B success:
  - frame_cnt increments.
  - If frame_cnt+1 == latched frame_num: IDLE, done pulse the same cycle busy falls.
  - Else: back to WR_START.
- At most one outstanding AXI transaction; no AR while a write is pending.
- start while busy: ignored; frame_num changes while busy: ignored.
- frame_cnt does not wrap (bounded by frame_num); counter width is FRAME_CNT_WIDTH.

Optional Feature:
- Macro UPSP_SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_DONE and every handshake-waiting state and resets on each state change. At TIMEOUT_CYCLES it sets err, drops all valids/readies and returns to IDLE with a done pulse.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- frame_num=3, slave always ready OKAY, interrupt_updone 20 cycles after each UPSTART write, rdata=16'h1234: exactly 3 UPSTART/UPEND write pairs at addr 0x0/0x4; frame_cnt=3, last_hskcnt=0x1234, single done pulse, err=0.
- awready delayed 5 cycles, wready immediate, then reversed: awvalid/wvalid each drop on their own handshake, no duplicate beat, bready asserted only after both accepted.
- bresp=2'b10 on the second UPSTART write: err=1, done pulse, frame_cnt=1, no further AXI traffic.
- start with frame_num=0: done pulses 1 cycle later, no AXI valid ever asserted, busy stays 0.
- rst_n low during WAIT_DONE of frame 2: all outputs 0 asynchronously; new start with frame_num=1 completes normally.
- UPSP_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=64, interrupt_updone held 0: err=1 and done pulse 64 cycles after WAIT_DONE entry.
